sopc_run_ctrl: RTL and testbench
================================

Name: sopc_run_ctrl

Overview:
- Parametrised reset-sequencing and run-supervision block for the minimal SOPC.
- Replaces fixed-delay reset release and fixed stop time with counted, per-channel, staggered reset release, a cycle-budget timeout, and halt detection on the fetch PC.
- Sits between the board or bench reset and the SOPC sub-blocks (CPU, inst ROM, data RAM); reports run status to the bench or to debug logic.

Parameters:
- NUM_RST, 2: number of independent reset channels; channel 0 is released first.
- RST_HOLD, 10: cycles all channels stay in reset after leaving S_RESET entry; legal range 1 to 2^CNT_W-1.
- STAGGER, 1: cycles between successive channel releases; 0 means all channels release on the same cycle.
- MAX_CYCLES, 75: run budget in cycles, counted from the release of the last channel; 0 disables the timeout.
- HALT_CYCLES, 8: consecutive valid, identical PC samples needed to declare halt; minimum 2.
- PC_W, 32: PC width.
- CNT_W, 32: cycle counter width.

Ports:
- clk, in, 1: system clock; all state is on the rising edge.
- rst, in, 1: asynchronous, active-low reset.
- start_i, in, 1: single-cycle request to re-run from S_DONE.
- pc_i, in, PC_W: fetch PC from the CPU.
- pc_valid_i, in, 1: pc_i is meaningful this cycle.
- rst_o, out, NUM_RST: per-channel reset to sub-blocks, active-high (RstEnable = 1).
- run_o, out, 1: high in S_RUN.
- done_o, out, 1: high in S_DONE.
- timeout_o, out, 1: sticky; S_DONE was entered by budget expiry.
- halt_o, out, 1: sticky; S_DONE was entered by halt detection.
- cycle_cnt_o, out, CNT_W: run cycles counted in the current or last run.

Behaviour:
- Reset values (rst low): state S_HOLD, rst_o all ones, run_o 0, done_o 0, timeout_o 0, halt_o 0, cycle_cnt_o 0, internal counters 0, last-PC register 0.
- Reset taken mid-run: all state returns to the reset values immediately (asynchronous), with no need for a clock edge.

States and transitions:
- S_HOLD:
  - Counts up to RST_HOLD cycles after rst rises.
  - On the cycle the count reaches RST_HOLD-1, transitions to S_REL.
  - Does not release channel 0 itself; channel 0 clears on S_REL entry.
- S_REL:
  - Channel k clears on the clock edge that lands k*STAGGER cycles after S_REL entry.
  - A channel, once released, stays released until the next S_HOLD entry.
  - After channel NUM_RST-1 is released, transitions to S_RUN on the same edge.
  - With STAGGER=0 or NUM_RST=1, S_REL lasts exactly one cycle.
- S_RUN:
  - run_o is 1.
  - cycle_cnt_o increments every cycle and saturates at all ones; it does not wrap.
  - Halt detector:
    - On a cycle with pc_valid_i=1 and pc_i equal to the last valid PC, the match counter increments.
    - On a cycle with pc_valid_i=1 and a different pc_i, the match counter loads 1 and the last-PC register updates.
    - On a cycle with pc_valid_i=0, the counter holds.
    - The first valid sample after S_RUN entry always loads the counter with 1.
  - Halt: when the match counter reaches HALT_CYCLES, set halt_o and go to S_DONE.
  - Timeout: when MAX_CYCLES≠0 and cycle_cnt_o reaches MAX_CYCLES, set timeout_o and go to S_DONE.
  - If halt and timeout occur on the same cycle, both flags are set.
- S_DONE:
  - done_o is 1; run_o is 0.
  - rst_o stays deasserted; the design is frozen only logically, not held in reset.
  - cycle_cnt_o holds its value.
  - start_i=1 sends the block to S_HOLD: rst_o all ones, timeout_o, halt_o, cycle_cnt_o and the halt detector all cleared on that edge.
  - start_i in any other state is ignored.

Latency:
- rst_o[0] first reads 0 exactly RST_HOLD+1 rising edges after rst deasserts.
- rst_o[k] first reads 0 k*STAGGER cycles after rst_o[0].

Decomposition:
- Shared package / defines file:
  - FSM state encoding (S_HOLD, S_REL, S_RUN, S_DONE), 2 bits.
  - Reuse the existing RstEnable/RstDisable constants for rst_o polarity.
- One sub-module: sopc_halt_det, containing the PC compare, last-PC register and saturating match counter.
  - Ports: clk, rst, clr, en, pc_i, pc_valid_i, halt_o.
  - Parameters: PC_W, HALT_CYCLES.

Test Plan:
- Power-up sequence:
  - Stimulus: defaults; rst low 3 cycles, then high.
  - Response: rst_o=2'b11 until 11 edges after rst rises; then rst_o[0]=0; one cycle later rst_o=2'b00 and run_o=1.
- Timeout:
  - Stimulus: defaults; PC incrementing by 4 every cycle.
  - Response: run_o high for 75 cycles; then done_o=1, timeout_o=1, halt_o=0, cycle_cnt_o=75.
- Halt:
  - Stimulus: PC increments to 0x20, then stays at 0x20 with pc_valid_i=1; pc_valid_i held low for 2 cycles in the middle of the repeats.
  - Response: halt_o and done_o set after 8 valid matching samples (10 cycles at 0x20); timeout_o=0.
- Simultaneous termination:
  - Stimulus: MAX_CYCLES=20, HALT_CYCLES=4; PC frozen so the 4th match lands on cycle 20.
  - Response: timeout_o=1 and halt_o=1 on the same edge.
- Re-run and reset mid-run:
  - Stimulus: start_i pulse in S_DONE; then rst driven low during S_RUN with no clock edge.
  - Response: after start_i, flags cleared, rst_o=all ones and the full sequence repeats; after rst low, rst_o=all ones and run_o=0 immediately.
- Parameter sweep:
  - Stimulus: NUM_RST=4, STAGGER=3.
  - Response: channels release at offsets 0, 3, 6 and 9 cycles; STAGGER=0 releases all four on the same edge.

Source files
------------

// File: rtl/sopc_run_ctrl_pkg.sv
// sopc_run_ctrl_pkg: shared FSM encoding and reset polarity for the SOPC run controller.
package sopc_run_ctrl_pkg;
  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_REL  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;
  localparam logic RstEnable  = 1'b1;
  localparam logic RstDisable = 1'b0;
endpackage

// File: rtl/sopc_halt_det.sv
// sopc_halt_det: counts consecutive valid, identical fetch PCs and flags a halt.
module sopc_halt_det #(
  parameter int PC_W        = 32,
  parameter int HALT_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [PC_W-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            halt_o
);
  localparam int MW = $clog2(HALT_CYCLES + 1);
  localparam logic [MW-1:0] HALT_N = MW'(HALT_CYCLES);
  logic [MW-1:0]   cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  // A zero count means no valid sample since the last clear, so the next one always reloads.
  always_comb begin
    cnt_d = cnt_q;
    pc_d  = pc_q;
    if (clr) begin
      cnt_d = '0;
      pc_d  = '0;
    end else if (en && pc_valid_i) begin
      if (cnt_q != '0 && pc_i == pc_q) cnt_d = (cnt_q == HALT_N) ? cnt_q : cnt_q + 1'b1;
      else begin
        cnt_d = MW'(1);
        pc_d  = pc_i;
      end
    end
  end
  assign halt_o = en && pc_valid_i && (cnt_d == HALT_N);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      pc_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
    end
  end
endmodule

// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: staggered reset release, run-cycle budget and halt supervision for the SOPC.
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int NUM_RST     = 2,
  parameter int RST_HOLD    = 10,
  parameter int STAGGER     = 1,
  parameter int MAX_CYCLES  = 75,
  parameter int HALT_CYCLES = 8,
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               pc_valid_i,
  output logic [NUM_RST-1:0] rst_o,
  output logic               run_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic               halt_o,
  output logic [CNT_W-1:0]   cycle_cnt_o
);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((NUM_RST - 1) * STAGGER);
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cyc_q, cyc_d, cyc_inc;
  logic [NUM_RST-1:0]   rst_q, rst_d;
  logic                 timeout_q, timeout_d, halt_q, halt_d;
  logic                 det_halt, clr;
  assign clr     = (state_q == S_DONE) && start_i;
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
  sopc_halt_det #(.PC_W(PC_W), .HALT_CYCLES(HALT_CYCLES)) u_halt_det (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .en        (run_o),
    .pc_i      (pc_i),
    .pc_valid_i(pc_valid_i),
    .halt_o    (det_halt)
  );
  // cnt_q is shared: hold length in S_HOLD, release offset in S_REL, idle at zero otherwise.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    rst_d     = rst_q;
    timeout_d = timeout_q;
    halt_d    = halt_q;
    case (state_q)
      S_HOLD: begin
        cnt_d   = (cnt_q == HOLD_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == HOLD_LAST) ? S_REL : S_HOLD;
      end
      S_REL: begin
        for (int k = 0; k < NUM_RST; k++)
          if (cnt_q == CNT_W'(k * STAGGER)) rst_d[k] = RstDisable;
        cnt_d   = (cnt_q == REL_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == REL_LAST) ? S_RUN : S_REL;
      end
      S_RUN: begin
        cyc_d     = cyc_inc;
        timeout_d = (MAX_CYCLES != 0) && (cyc_inc == MAX_C);
        halt_d    = det_halt;
        state_d   = (timeout_d || halt_d) ? S_DONE : S_RUN;
      end
      S_DONE: begin
        if (start_i) begin
          state_d   = S_HOLD;
          rst_d     = {NUM_RST{RstEnable}};
          timeout_d = 1'b0;
          halt_d    = 1'b0;
          cyc_d     = '0;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      cyc_q     <= '0;
      rst_q     <= {NUM_RST{RstEnable}};
      timeout_q <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cyc_q     <= cyc_d;
      rst_q     <= rst_d;
      timeout_q <= timeout_d;
      halt_q    <= halt_d;
    end
  end
  assign rst_o       = rst_q;
  assign run_o       = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign timeout_o   = timeout_q;
  assign halt_o      = halt_q;
  assign cycle_cnt_o = cyc_q;
endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl: directed scoreboard bench for sopc_run_ctrl across four parameter sets.
module tb_sopc_run_ctrl;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, v0 = 1'b0, v1 = 1'b0;
  logic [31:0] pc0 = '0, pc1 = 32'h100;
  logic [1:0]  r0, r1;
  logic [3:0]  r2, r3, m0, m2;
  logic        run0, run1, run2, run3, done0, done1, done2, done3;
  logic        to0, to1, to2, to3, ht0, ht1, ht2, ht3;
  logic [31:0] cyc0, cyc1, cyc2, cyc3;
  logic [63:0] exp_q[$];
  string       tag_q[$];
  int          pass = 0, total = 0;

  always #5 clk = ~clk;

  sopc_run_ctrl u0 (
    .clk(clk), .rst(rst), .start_i(start), .pc_i(pc0), .pc_valid_i(v0),
    .rst_o(r0), .run_o(run0), .done_o(done0), .timeout_o(to0), .halt_o(ht0), .cycle_cnt_o(cyc0)
  );
  sopc_run_ctrl #(.MAX_CYCLES(20), .HALT_CYCLES(4)) u1 (
    .clk(clk), .rst(rst), .start_i(start), .pc_i(pc1), .pc_valid_i(v1),
    .rst_o(r1), .run_o(run1), .done_o(done1), .timeout_o(to1), .halt_o(ht1), .cycle_cnt_o(cyc1)
  );
  sopc_run_ctrl #(.NUM_RST(4), .STAGGER(3)) u2 (
    .clk(clk), .rst(rst), .start_i(start), .pc_i(pc0), .pc_valid_i(v0),
    .rst_o(r2), .run_o(run2), .done_o(done2), .timeout_o(to2), .halt_o(ht2), .cycle_cnt_o(cyc2)
  );
  sopc_run_ctrl #(.NUM_RST(4), .STAGGER(0)) u3 (
    .clk(clk), .rst(rst), .start_i(start), .pc_i(pc0), .pc_valid_i(v0),
    .rst_o(r3), .run_o(run3), .done_o(done3), .timeout_o(to3), .halt_o(ht3), .cycle_cnt_o(cyc3)
  );

  task automatic want(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic got(input logic [63:0] o);
    logic [63:0] e;
    string       t;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty: got %0h want <none>", o);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    assert (o === e) pass = pass + 1;
    else $error("FAIL %s: got %0h want %0h", t, o, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values while rst is held low.
    want("rst_rst_o", 2'b11); want("rst_run", 0); want("rst_done", 0);
    want("rst_cyc", 0); want("rst_flags", 0); want("rst_u2_rst_o", 4'hF);
    step(3);
    got(r0); got(run0); got(done0); got(cyc0); got({to0, ht0}); got(r2);
    // Power-up: edge e counts rising edges after rst goes high.
    rst = 1'b1;
    v0  = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      for (int k = 0; k < 4; k++) begin
        m0[k] = (e < 11 + k);
        m2[k] = (e < 11 + 3 * k);
      end
      want("pu_u0_rst_o", m0[1:0]); want("pu_u2_rst_o", m2);
      want("pu_u3_rst_o", (e < 11) ? 4'hF : 4'h0);
      want("pu_u0_run", e >= 12); want("pu_u2_run", e >= 20); want("pu_u3_run", e >= 11);
      step(1);
      pc0 += 4;
      got(r0); got(r2); got(r3); got(run0); got(run2); got(run3);
    end
    // Timeout on u0 (run from edge 12) and simultaneous halt+timeout on u1.
    for (int e = 21; e <= 90; e++) begin
      if (e == 31) want("sim_u1_done_early", 0);
      if (e == 32) begin want("sim_u1_flags", 2'b11); want("sim_u1_done", 1); want("sim_u1_cyc", 20); end
      if (e == 86) begin want("to_run_last", 1); want("to_cyc_last", 74); end
      if (e == 87) begin
        want("to_done", 1); want("to_flags", 2'b10); want("to_cyc", 75); want("to_run_off", 0);
      end
      if (e == 90) begin want("to_cyc_hold", 75); want("to_rst_o_off", 2'b00); end
      step(1);
      pc0 += 4;
      if (e == 28) v1 = 1'b1;
      if (e == 31) got(done1);
      if (e == 32) begin got({to1, ht1}); got(done1); got(cyc1); end
      if (e == 86) begin got(run0); got(cyc0); end
      if (e == 87) begin got(done0); got({to0, ht0}); got(cyc0); got(run0); end
      if (e == 90) begin got(cyc0); got(r0); end
    end
    // Re-run: start clears u0, is ignored by u2 which is still running.
    start = 1'b1;
    want("start_rst_o", 2'b11); want("start_flags", 0); want("start_cyc", 0);
    want("start_done", 0); want("start_u2_ignored", 1);
    step(1);
    start = 1'b0;
    got(r0); got({to0, ht0}); got(cyc0); got(done0); got(run2);
    // Second run on u0 ends by halt at PC 0x20 with a 2-cycle valid gap.
    for (int e = 92; e <= 115; e++) begin
      if (e == 101) want("rr_rst_o_hold", 2'b11);
      if (e == 102) want("rr_rst_o_ch0", 2'b10);
      if (e == 103) begin want("rr_rst_o_all", 2'b00); want("rr_run", 1); end
      if (e == 114) want("halt_done_early", 0);
      if (e == 115) begin want("halt_flags", 2'b01); want("halt_done", 1); want("halt_cyc", 12); end
      step(1);
      if (e < 103) pc0 += 4;
      if (e == 103) pc0 = 32'h18;
      if (e == 104) pc0 = 32'h1C;
      if (e == 105) pc0 = 32'h20;
      if (e == 108) v0 = 1'b0;
      if (e == 110) v0 = 1'b1;
      if (e == 101 || e == 102) got(r0);
      if (e == 103) begin got(r0); got(run0); end
      if (e == 114) got(done0);
      if (e == 115) begin got({to0, ht0}); got(done0); got(cyc0); end
    end
    // Third run, then asynchronous reset between clock edges.
    start = 1'b1;
    want("rs_rst_o", 2'b11); want("rs_flags", 0); want("rs_done", 0);
    step(1);
    start = 1'b0;
    v0    = 1'b0;
    got(r0); got({to0, ht0}); got(done0);
    want("rs_run", 1); want("rs_cyc", 2);
    step(14);
    got(run0); got(cyc0);
    #2 rst = 1'b0;
    want("async_rst_o", 2'b11); want("async_run", 0); want("async_cyc", 0);
    want("async_done", 0); want("async_u2_rst_o", 4'hF);
    #1;
    got(r0); got(run0); got(cyc0); got(done0); got(r2);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
